// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for the 5-stage RV32 core.
//                Generates stall/flush strobes for the IF/ID, ID/EX, EX/MEM
//                and MEM/WB registers, selects EX operand forwarding, holds
//                EX for multi-cycle ALU ops and for slow data memory, and
//                flags a sticky error when a memory wait runs too long.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MC_LAT      = 4,    // total EX-occupancy cycles of a multi-cycle op
  parameter int MEM_TIMEOUT = 255   // max consecutive memory-wait cycles
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_Rs1D,
  input  logic [4:0] i_Rs2D,
  input  logic [4:0] i_Rs1E,
  input  logic [4:0] i_Rs2E,
  input  logic [4:0] i_RdE,
  input  logic [1:0] i_resultSrcE,
  input  logic       i_pcSrcE,
  input  logic       i_mcStartE,
  input  logic [4:0] i_RdM,
  input  logic [4:0] i_RdW,
  input  logic       i_regWriteM,
  input  logic       i_regWriteW,
  input  logic       i_memReqM,
  input  logic       i_memReadyM,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_stallE,
  output logic       o_stallM,
  output logic       o_flushD,
  output logic       o_flushE,
  output logic       o_flushM,
  output logic       o_flushW,
  output logic [1:0] o_forwardAE,
  output logic [1:0] o_forwardBE,
  output logic       o_memErr
);

  // Counter widths: the multi-cycle counter holds up to MC_LAT-2, the memory
  // wait counter saturates at MEM_TIMEOUT.
  localparam int c_MC_W  = $clog2(MC_LAT) + 1;
  localparam int c_MEM_W = $clog2(MEM_TIMEOUT + 1);

  // MC_LAT==1 means the op fits in a single EX cycle, so the FSM never engages.
  localparam bit                 c_MC_EN    = (MC_LAT > 1);
  localparam logic [c_MC_W-1:0]  c_MC_LOAD  = c_MC_W'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
  localparam logic [c_MEM_W-1:0] c_MEM_LAST = c_MEM_W'(MEM_TIMEOUT - 1);
  localparam logic [c_MEM_W-1:0] c_MEM_MAX  = c_MEM_W'(MEM_TIMEOUT);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_BUSY = 1'b1;

  logic [0:0]         r_mcState;
  logic [c_MC_W-1:0]  r_mcCnt;
  logic [c_MEM_W-1:0] r_memCnt;
  logic               r_memErr;

  logic [0:0]         w_mcStateNxt;
  logic [c_MC_W-1:0]  w_mcCntNxt;
  logic               w_mcStall;
  logic               w_memStall;
  logic               w_lwStall;
  logic               w_fwdAM;
  logic               w_fwdAW;
  logic               w_fwdBM;
  logic               w_fwdBW;

  assign w_memStall = i_memReqM && !i_memReadyM;

  // A load in EX whose destination is read by the instruction in ID.
  assign w_lwStall = (i_resultSrcE == 2'b01) && (i_RdE != 5'd0) &&
                     ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));

  assign w_fwdAM = i_regWriteM && (i_RdM != 5'd0) && (i_RdM == i_Rs1E);
  assign w_fwdAW = i_regWriteW && (i_RdW != 5'd0) && (i_RdW == i_Rs1E);
  assign w_fwdBM = i_regWriteM && (i_RdM != 5'd0) && (i_RdM == i_Rs2E);
  assign w_fwdBW = i_regWriteW && (i_RdW != 5'd0) && (i_RdW == i_Rs2E);

  // Multi-cycle FSM next-state: the start cycle counts as the first stall
  // cycle, and the final (count zero) cycle releases EX. A memory stall
  // freezes both the count and the state so no EX cycle is lost.
  always_comb begin
    w_mcStall    = 1'b0;
    w_mcStateNxt = r_mcState;
    w_mcCntNxt   = r_mcCnt;
    if (r_mcState == c_ST_IDLE) begin
      if (i_mcStartE && c_MC_EN && !w_memStall) begin
        w_mcStall    = 1'b1;
        w_mcStateNxt = c_ST_BUSY;
        w_mcCntNxt   = c_MC_LOAD;
      end
    end else begin
      if (r_mcCnt != '0) begin
        w_mcStall = 1'b1;
        if (!w_memStall) begin
          w_mcCntNxt = r_mcCnt - c_MC_W'(1);
        end
      end else if (!w_memStall) begin
        w_mcStateNxt = c_ST_IDLE;
      end
    end
  end

  // Multi-cycle FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcState <= c_ST_IDLE;
      r_mcCnt   <= '0;
    end else begin
      r_mcState <= w_mcStateNxt;
      r_mcCnt   <= w_mcCntNxt;
    end
  end

  // Memory wait counter (saturating) and sticky timeout error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memCnt <= '0;
      r_memErr <= 1'b0;
    end else if (w_memStall) begin
      if (r_memCnt != c_MEM_MAX) begin
        r_memCnt <= r_memCnt + c_MEM_W'(1);
      end
      if (r_memCnt == c_MEM_LAST) begin
        r_memErr <= 1'b1;
      end
    end else begin
      r_memCnt <= '0;
    end
  end

  // Prioritised stall/flush decode plus forwarding selects; everything is
  // forced low while reset is asserted, independent of the clock.
  always_comb begin
    o_stallF    = 1'b0;
    o_stallD    = 1'b0;
    o_stallE    = 1'b0;
    o_stallM    = 1'b0;
    o_flushD    = 1'b0;
    o_flushE    = 1'b0;
    o_flushM    = 1'b0;
    o_flushW    = 1'b0;
    o_forwardAE = 2'b00;
    o_forwardBE = 2'b00;
    if (rst_n) begin
      if (w_fwdAM)      o_forwardAE = 2'b10;
      else if (w_fwdAW) o_forwardAE = 2'b01;
      if (w_fwdBM)      o_forwardBE = 2'b10;
      else if (w_fwdBW) o_forwardBE = 2'b01;

      if (w_memStall) begin
        // Freeze everything up to MEM; WB receives a bubble.
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_stallM = 1'b1;
        o_flushW = 1'b1;
      end else if (w_mcStall) begin
        // Hold EX and upstream; MEM receives a bubble.
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_flushM = 1'b1;
      end else if (i_pcSrcE) begin
        // EX is advancing here, so the resolved redirect takes effect.
        o_flushD = 1'b1;
        o_flushE = 1'b1;
      end else if (w_lwStall) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_flushE = 1'b1;
      end
    end
  end

  assign o_memErr = r_memErr;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed scoreboard bench for hazard_ctrl. Stimulus pushes
//                hand-computed expectations; a negedge monitor pops/compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] resultSrcE;
  logic       pcSrcE, mcStartE, regWriteM, regWriteW, memReqM, memReadyM;

  logic       a_sF, a_sD, a_sE, a_sM, a_fD, a_fE, a_fM, a_fW, a_err;
  logic [1:0] a_fa, a_fb;
  logic       b_sF, b_sD, b_sE, b_sM, b_fD, b_fE, b_fM, b_fW, b_err;
  logic [1:0] b_fa, b_fb;

  // Instance A: 4-cycle multi-cycle ops, short memory timeout.
  hazard_ctrl #(.MC_LAT(4), .MEM_TIMEOUT(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_Rs1D(Rs1D), .i_Rs2D(Rs2D), .i_Rs1E(Rs1E), .i_Rs2E(Rs2E), .i_RdE(RdE),
    .i_resultSrcE(resultSrcE), .i_pcSrcE(pcSrcE), .i_mcStartE(mcStartE),
    .i_RdM(RdM), .i_RdW(RdW), .i_regWriteM(regWriteM), .i_regWriteW(regWriteW),
    .i_memReqM(memReqM), .i_memReadyM(memReadyM),
    .o_stallF(a_sF), .o_stallD(a_sD), .o_stallE(a_sE), .o_stallM(a_sM),
    .o_flushD(a_fD), .o_flushE(a_fE), .o_flushM(a_fM), .o_flushW(a_fW),
    .o_forwardAE(a_fa), .o_forwardBE(a_fb), .o_memErr(a_err)
  );

  // Instance B: single-cycle "multi-cycle" ops, default timeout.
  hazard_ctrl #(.MC_LAT(1), .MEM_TIMEOUT(255)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_Rs1D(Rs1D), .i_Rs2D(Rs2D), .i_Rs1E(Rs1E), .i_Rs2E(Rs2E), .i_RdE(RdE),
    .i_resultSrcE(resultSrcE), .i_pcSrcE(pcSrcE), .i_mcStartE(mcStartE),
    .i_RdM(RdM), .i_RdW(RdW), .i_regWriteM(regWriteM), .i_regWriteW(regWriteW),
    .i_memReqM(memReqM), .i_memReadyM(memReadyM),
    .o_stallF(b_sF), .o_stallD(b_sD), .o_stallE(b_sE), .o_stallM(b_sM),
    .o_flushD(b_fD), .o_flushE(b_fE), .o_flushM(b_fM), .o_flushW(b_fW),
    .o_forwardAE(b_fa), .o_forwardBE(b_fb), .o_memErr(b_err)
  );

  // Control byte order: {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
  localparam logic [7:0] c_NONE = 8'b0000_0000;
  localparam logic [7:0] c_MEM  = 8'b1111_0001;
  localparam logic [7:0] c_MC   = 8'b1110_0010;
  localparam logic [7:0] c_RDIR = 8'b0000_1100;
  localparam logic [7:0] c_LW   = 8'b1100_0100;

  typedef struct {
    string       name;
    int          inst;
    logic [14:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [14:0] w_vecA, w_vecB;
  assign w_vecA = {a_sF, a_sD, a_sE, a_sM, a_fD, a_fE, a_fM, a_fW, a_fa, a_fb, a_err};
  assign w_vecB = {b_sF, b_sD, b_sE, b_sM, b_fD, b_fE, b_fM, b_fW, b_fa, b_fb, b_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input int inst, input logic [7:0] ctl,
                            input logic [1:0] fa, input logic [1:0] fb, input logic err);
    exp_t e;
    e.name = n;
    e.inst = inst;
    e.exp  = {ctl, fa, fb, err};
    q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so every pushed expectation is
  // compared at the falling edge of the cycle it was issued in.
  always @(negedge clk) begin
    exp_t e;
    logic [14:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = (e.inst == 0) ? w_vecA : w_vecB;
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s (dut %0d): got %b required %b", e.name, e.inst, act, e.exp);
      end
    end
  end

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    resultSrcE = 2'b00; pcSrcE = 0; mcStartE = 0;
    regWriteM = 0; regWriteW = 0; memReqM = 0; memReadyM = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Reset: outputs forced low even with forwarding and memory-wait inputs active.
    RdM = 5; regWriteM = 1; Rs1E = 5; memReqM = 1;
    #2;
    expect_out("reset_outs", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    expect_out("reset_outs", 1, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    clear_inputs();
    tick();
    rst_n = 1'b1;

    // 1: forwarding, MEM wins over WB; RdM=0 falls back to WB; RdW=0 none.
    tick();
    RdM = 5; regWriteM = 1; Rs1E = 5; RdW = 5; regWriteW = 1;
    expect_out("fwd_mem_wins", 0, c_NONE, 2'b10, 2'b00, 1'b0);
    tick();
    RdM = 0; Rs2E = 5;
    expect_out("fwd_wb", 0, c_NONE, 2'b01, 2'b01, 1'b0);
    tick();
    RdM = 5; RdW = 0;
    expect_out("fwd_mem_b", 0, c_NONE, 2'b10, 2'b10, 1'b0);
    tick();
    regWriteM = 0;
    expect_out("fwd_rdw_zero", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    clear_inputs();

    // 2: load-use hazard, then RdE=0 suppresses it.
    resultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    expect_out("lw_stall", 0, c_LW, 2'b00, 2'b00, 1'b0);
    tick();
    resultSrcE = 2'b00;
    expect_out("lw_gone", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    resultSrcE = 2'b01; RdE = 0; Rs2D = 0; Rs1D = 0;
    expect_out("lw_rd0", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    clear_inputs();

    // 3: multi-cycle op: 3 stall cycles then release; MC_LAT=1 never stalls.
    mcStartE = 1;
    for (int i = 0; i < 3; i++) begin
      expect_out("mc_stall", 0, c_MC, 2'b00, 2'b00, 1'b0);
      expect_out("mc_lat1", 1, c_NONE, 2'b00, 2'b00, 1'b0);
      tick();
    end
    expect_out("mc_release", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    mcStartE = 0;
    expect_out("mc_idle", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();

    // 4: redirect beats load-use; redirect held back until mc release.
    resultSrcE = 2'b01; RdE = 7; Rs2D = 7; pcSrcE = 1;
    expect_out("redirect_over_lw", 0, c_RDIR, 2'b00, 2'b00, 1'b0);
    tick();
    clear_inputs();
    mcStartE = 1; pcSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      expect_out("mc_hides_redirect", 0, c_MC, 2'b00, 2'b00, 1'b0);
      tick();
    end
    expect_out("redirect_on_release", 0, c_RDIR, 2'b00, 2'b00, 1'b0);
    tick();
    clear_inputs();
    tick();

    // 5a: memory stall in the middle of a multi-cycle op freezes its count.
    mcStartE = 1;
    expect_out("mcm_c1", 0, c_MC, 2'b00, 2'b00, 1'b0);
    tick();
    expect_out("mcm_c2", 0, c_MC, 2'b00, 2'b00, 1'b0);
    tick();
    memReqM = 1; memReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      expect_out("mem_stall", 0, c_MEM, 2'b00, 2'b00, 1'b0);
      tick();
    end
    memReadyM = 1;
    expect_out("mcm_resume", 0, c_MC, 2'b00, 2'b00, 1'b0);
    tick();
    memReqM = 0; memReadyM = 0;
    expect_out("mcm_release", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    mcStartE = 0;
    expect_out("mcm_idle", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();

    // 5b: four wait cycles reach the timeout; error is sticky.
    memReqM = 1; memReadyM = 0;
    for (int i = 0; i < 4; i++) begin
      expect_out("timeout_wait", 0, c_MEM, 2'b00, 2'b00, 1'b0);
      tick();
    end
    memReqM = 0;
    expect_out("mem_err_set", 0, c_NONE, 2'b00, 2'b00, 1'b1);
    expect_out("mem_err_lat1", 1, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    expect_out("mem_err_sticky", 0, c_NONE, 2'b00, 2'b00, 1'b1);
    tick();

    // 6: asynchronous reset during BUSY and memStall.
    mcStartE = 1;
    expect_out("rst_pre_mc", 0, c_MC, 2'b00, 2'b00, 1'b1);
    tick();
    memReqM = 1;
    expect_out("rst_pre_mem", 0, c_MEM, 2'b00, 2'b00, 1'b1);
    tick();
    RdM = 5; regWriteM = 1; Rs1E = 5;
    rst_n = 1'b0;
    expect_out("rst_async", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    expect_out("rst_after", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    expect_out("rst_after2", 0, c_NONE, 2'b00, 2'b00, 1'b0);
    tick();
    tick();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
